encoder_8x3: RTL and testbench
==============================

Name: encoder_8x3

Overview:
Registered 8-to-3 binary encoder with priority resolution. Converts an 8-bit request vector, normally one-hot, into a 3-bit index plus a valid flag and a multi-hot flag. Used wherever a one-hot select or request bus must be compressed to a binary index, for example in arbiter grant encoding or interrupt-number generation. Encoding is implemented as a combinational function, and the output is registered on the clock.

Parameters:
MSB_PRIORITY, default 1, selects the winner when more than one input bit is set: 1 = highest set bit wins, 0 = lowest set bit wins.

Ports:
clk      input   1  system clock, rising-edge active
rst_n    input   1  asynchronous active-low reset
in       input   8  request vector, bit i = request i
y        output  3  registered encoded index of the winning request
valid    output  1  registered; 1 when at least one bit of in was set
multi    output  1  registered; 1 when two or more bits of in were set

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, y=3'b000, valid=0 and multi=0, immediately and independently of clk. The first capture occurs on the first rising clk edge after rst_n deasserts.
- Latency: exactly 1 cycle. in sampled at rising edge N appears on y, valid and multi after edge N. There is no handshake; the block captures every cycle.
- One-hot input (in = 1<<i, i=0..7): y=i, valid=1, multi=0.
- in = 8'h00: y=3'b000, valid=0, multi=0. Consumers must qualify y with valid.
- Multi-hot input:
  - MSB_PRIORITY=1: y = index of the highest set bit.
  - MSB_PRIORITY=0: y = index of the lowest set bit.
  - In both cases valid=1 and multi=1.
- in = 8'hFF: y=7 when MSB_PRIORITY=1, y=0 when MSB_PRIORITY=0; valid=1, multi=1.
- Combinational structure:
  - A function computes the index.
  - A second function computes the multi-hot flag, defined as (in & (in-1)) != 0.
  - Register all outputs; no output may have a combinational path from in.
- Reset asserted mid-stream: outputs clear asynchronously. Input values present during reset are not captured.
- X/Z on in: no defined output requirement; simulation behaviour is not checked.

Optional Feature:
ENCODER_8X3_POPCOUNT_EN
- Defined: adds output port ones_cnt (4 bits), registered with the same 1-cycle latency as y. It holds the number of set bits in in (0..8) and resets to 4'd0.
- Not defined: the port and its logic are absent, and the interface is exactly the ports listed above.

Test Plan:
- Reset: hold rst_n=0 with in=8'hA5 for 3 clocks -> y=0, valid=0, multi=0. Deassert rst_n; one edge later -> y=7 (MSB_PRIORITY=1), valid=1, multi=1.
- Walking one: for i=0..7 apply in=8'b1<<i for 10 time units each -> one edge after each apply, y=i, valid=1, multi=0 (e.g. in=8'b00010000 -> y=3'b100).
- Zero input: in=8'h00 -> y=0, valid=0, multi=0 one cycle later.
- Priority check: in=8'b0100_0010:
  - MSB_PRIORITY=1 -> y=6, valid=1, multi=1.
  - MSB_PRIORITY=0 -> y=1, valid=1, multi=1.
- Async reset mid-run: with in=8'h80 and y=7, drop rst_n between clock edges -> y=0, valid=0 immediately, without waiting for a clock edge.
- With ENCODER_8X3_POPCOUNT_EN defined, apply in=8'hFF -> ones_cnt=8. Then apply in=8'h01 -> ones_cnt=1, y=0, valid=1.

Source files
------------

// File: rtl/encoder_8x3.sv
// -----------------------------------------------------------------------------
// encoder_8x3 -- registered 8-to-3 priority encoder
//
// Compresses an 8-bit request vector (normally one-hot) into a 3-bit binary
// index, a valid flag, and a multi-hot flag. All outputs are registered, so
// they appear one clock after the input is sampled. None of them has a
// combinational path from `in`.
//
// Parameters:
//   MSB_PRIORITY  1 (default): the highest set bit wins when several are set.
//                 0: the lowest set bit wins.
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   rst_n     in   1  asynchronous active-low reset
//   in        in   8  request vector, bit i = request i
//   y         out  3  encoded index of the winning request (0 when none)
//   valid     out  1  at least one bit of `in` was set
//   multi     out  1  two or more bits of `in` were set
//   ones_cnt  out  4  number of set bits in `in` (0..8)
//                     Present only when ENCODER_8X3_POPCOUNT_EN is defined.
//
// Optional feature macro: ENCODER_8X3_POPCOUNT_EN
// -----------------------------------------------------------------------------
module encoder_8x3 #(
  parameter int MSB_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  output logic [2:0] y,
  output logic       valid,
  output logic       multi
`ifdef ENCODER_8X3_POPCOUNT_EN
  ,
  output logic [3:0] ones_cnt
`endif
);

  // Index of the winning request bit. The scan runs toward the preferred end,
  // so the last hit overwrites earlier ones and leaves the winner. An all-zero
  // vector yields 0, and valid qualifies that result.
  function automatic logic [2:0] enc_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (MSB_PRIORITY != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits
  // were set.
  function automatic logic is_multi(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

`ifdef ENCODER_8X3_POPCOUNT_EN
  function automatic logic [3:0] pop_count(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction
`endif

  logic [2:0] y_next;
  logic       valid_next;
  logic       multi_next;

  always_comb begin
    y_next     = enc_index(in);
    valid_next = |in;
    multi_next = is_multi(in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 3'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      y     <= y_next;
      valid <= valid_next;
      multi <= multi_next;
    end
  end

`ifdef ENCODER_8X3_POPCOUNT_EN
  logic [3:0] ones_cnt_next;

  always_comb begin
    ones_cnt_next = pop_count(in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= 4'd0;
    end else begin
      ones_cnt <= ones_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_encoder_8x3.sv
// -----------------------------------------------------------------------------
// tb_encoder_8x3 -- directed self-checking bench for encoder_8x3
//
// Two instances share the same stimulus. One uses MSB priority and the other
// uses LSB priority, so the two winner-selection rules are checked side by
// side. Inputs change on the falling edge. Outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_v;

  logic [2:0] y_m;
  logic       valid_m;
  logic       multi_m;
  logic [2:0] y_l;
  logic       valid_l;
  logic       multi_l;
`ifdef ENCODER_8X3_POPCOUNT_EN
  logic [3:0] cnt_m;
  logic [3:0] cnt_l;
`endif

  int checks;
  int failures;

  encoder_8x3 #(.MSB_PRIORITY(1)) dut_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_v),
    .y        (y_m),
    .valid    (valid_m),
    .multi    (multi_m)
`ifdef ENCODER_8X3_POPCOUNT_EN
    ,
    .ones_cnt (cnt_m)
`endif
  );

  encoder_8x3 #(.MSB_PRIORITY(0)) dut_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_v),
    .y        (y_l),
    .valid    (valid_l),
    .multi    (multi_l)
`ifdef ENCODER_8X3_POPCOUNT_EN
    ,
    .ones_cnt (cnt_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the outputs of both instances against hand-computed values.
  task automatic check_all(input string tag, input logic [2:0] ym, input logic [2:0] yl,
                           input logic vld, input logic mlt);
    check({tag, " y_msb"}, 8'(y_m), 8'(ym));
    check({tag, " y_lsb"}, 8'(y_l), 8'(yl));
    check({tag, " valid_msb"}, 8'(valid_m), 8'(vld));
    check({tag, " valid_lsb"}, 8'(valid_l), 8'(vld));
    check({tag, " multi_msb"}, 8'(multi_m), 8'(mlt));
    check({tag, " multi_lsb"}, 8'(multi_l), 8'(mlt));
    $display("txn %-12s in=%02h y_msb=%0d y_lsb=%0d valid=%0b/%0b multi=%0b/%0b",
             tag, in_v, y_m, y_l, valid_m, valid_l, multi_m, multi_l);
  endtask

  // Apply a vector on the falling edge and sample one rising edge later.
  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    in_v = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_v     = 8'hA5;

    // Hold reset for 3 clocks with a non-zero input present.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 3'd0, 1'b0, 1'b0);

    // Release reset. The next edge captures 0xA5 (bits 7,5,2,0).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_cap", 3'd7, 3'd0, 1'b1, 1'b1);

    // Walking one: both priority modes agree for one-hot inputs.
    for (int i = 0; i < 8; i++) begin
      apply(8'b1 << i);
      check_all($sformatf("walk%0d", i), 3'(i), 3'(i), 1'b1, 1'b0);
    end

    apply(8'h00);
    check_all("zero", 3'd0, 3'd0, 1'b0, 1'b0);

    apply(8'b0100_0010);
    check_all("prio_42", 3'd6, 3'd1, 1'b1, 1'b1);

    apply(8'h18);
    check_all("prio_18", 3'd4, 3'd3, 1'b1, 1'b1);

    apply(8'hFF);
    check_all("all_ones", 3'd7, 3'd0, 1'b1, 1'b1);
`ifdef ENCODER_8X3_POPCOUNT_EN
    check("cnt_ff_msb", 8'(cnt_m), 8'd8);
    check("cnt_ff_lsb", 8'(cnt_l), 8'd8);
`endif

    apply(8'h01);
    check_all("bit0", 3'd0, 3'd0, 1'b1, 1'b0);
`ifdef ENCODER_8X3_POPCOUNT_EN
    check("cnt_01_msb", 8'(cnt_m), 8'd1);
    check("cnt_01_lsb", 8'(cnt_l), 8'd1);
`endif

    // Async reset between edges: the outputs clear without a clock edge.
    apply(8'h80);
    check_all("pre_async", 3'd7, 3'd7, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 3'd0, 3'd0, 1'b0, 1'b0);

    // The input seen across an edge while in reset is not captured.
    @(posedge clk);
    #1;
    check_all("rst_hold", 3'd0, 3'd0, 1'b0, 1'b0);
`ifdef ENCODER_8X3_POPCOUNT_EN
    check("cnt_rst", 8'(cnt_m), 8'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h0C);
    check_all("post_rst", 3'd3, 3'd2, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed run needs only a few hundred time units.
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
